// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: default channel count and activation width,
// the activation type and an unsigned max helper.
package cnn_pkg;

   localparam int CNN_NO_CH = 10;
   localparam int CNN_BW    = 3;
   localparam int UMAX_W    = 16;

   typedef logic [CNN_BW-1:0] act_t;

   // Operands are zero-extended by callers, so any width up to UMAX_W compares unsigned.
   function automatic logic [UMAX_W-1:0] umax(input logic [UMAX_W-1:0] a,
                                              input logic [UMAX_W-1:0] b);
      umax = (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/maxpool_time_stream_if.sv
// Stream bundle between the quantizer, the temporal max-pool and the next conv layer.
interface maxpool_time_stream_if #(
   parameter int NO_CH = cnn_pkg::CNN_NO_CH,
   parameter int BW    = cnn_pkg::CNN_BW
);
   logic                      vld_in;
   logic [NO_CH-1:0][BW-1:0]  data_in;
   logic                      vld_out;
   logic [NO_CH-1:0][BW-1:0]  data_out;
   logic                      last_out;

   modport master (output vld_in, output data_in,
                   input  vld_out, input data_out, input last_out);
   modport slave  (input  vld_in, input data_in,
                   output vld_out, output data_out, output last_out);
endinterface

// File: rtl/maxpool_time_stream_lane.sv
// One channel of the temporal max-pool: running-max register plus the
// registered pooled output, sequenced by strobes shared across all lanes.
module maxpool_time_stream_lane
   import cnn_pkg::*;
#(
   parameter int BW = CNN_BW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_i,
   input  logic          update_i,
   input  logic          emit_i,
   input  logic [BW-1:0] data_i,
   output logic [BW-1:0] data_o
);

   logic [BW-1:0] acc_q, acc_d;
   logic [BW-1:0] out_q, out_d;
   logic [BW-1:0] merged_s;

   // First beat of a window loads directly; later beats fold into the running max.
   always_comb begin
      merged_s = BW'(umax(UMAX_W'(acc_q), UMAX_W'(data_i)));
      if (load_i) begin
         merged_s = data_i;
      end else begin
         merged_s = BW'(umax(UMAX_W'(acc_q), UMAX_W'(data_i)));
      end
      if (load_i || update_i) begin
         acc_d = merged_s;
      end else begin
         acc_d = acc_q;
      end
      if (emit_i) begin
         out_d = merged_s;
      end else begin
         out_d = out_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
         out_q <= '0;
      end else begin
         acc_q <= acc_d;
         out_q <= out_d;
      end
   end

   assign data_o = out_q;

endmodule

// File: rtl/maxpool_time_stream.sv
// Streaming 1-D temporal max-pool with frame tracking and last-output marking.
// MAXPOOL_FLUSH_PARTIAL_EN: emit a pooled output over the trailing partial window of a frame.
module maxpool_time_stream
   import cnn_pkg::*;
#(
   parameter int NO_CH     = CNN_NO_CH,
   parameter int BW        = CNN_BW,
   parameter int POOL_SIZE = 2,
   parameter int SEQ_LEN   = 1024
) (
   input logic                   clk,
   input logic                   rst,
   maxpool_time_stream_if.slave  stream_io
);

   localparam int WIN_W     = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;
   localparam int SEQ_W     = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
   localparam int REM       = SEQ_LEN % POOL_SIZE;
   localparam int LAST_FULL = SEQ_LEN - REM - 1;

   localparam logic [WIN_W-1:0] WIN_MAX       = WIN_W'(POOL_SIZE - 1);
   localparam logic [SEQ_W-1:0] SEQ_MAX       = SEQ_W'(SEQ_LEN - 1);
   localparam logic [SEQ_W-1:0] SEQ_LAST_FULL = SEQ_W'(LAST_FULL);

   logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
   logic [SEQ_W-1:0] seq_cnt_q, seq_cnt_d;
   logic             vld_q, vld_d;
   logic             last_q, last_d;
   logic             win_end_s, frame_end_s;
   logic             load_s, update_s, emit_s;
   logic [NO_CH-1:0][BW-1:0] data_s;

   // Position tracking; a frame end also closes whatever window is open.
   always_comb begin
      win_end_s   = (win_cnt_q == WIN_MAX);
      frame_end_s = (seq_cnt_q == SEQ_MAX);
      if (stream_io.vld_in) begin
         if (frame_end_s || win_end_s) begin
            win_cnt_d = '0;
         end else begin
            win_cnt_d = win_cnt_q + 1'b1;
         end
         if (frame_end_s) begin
            seq_cnt_d = '0;
         end else begin
            seq_cnt_d = seq_cnt_q + 1'b1;
         end
      end else begin
         win_cnt_d = win_cnt_q;
         seq_cnt_d = seq_cnt_q;
      end
   end

   // Lane strobes and the frame-tail policy.
   always_comb begin
      load_s   = stream_io.vld_in && (win_cnt_q == '0);
      update_s = stream_io.vld_in && (win_cnt_q != '0);
`ifdef MAXPOOL_FLUSH_PARTIAL_EN
      emit_s   = stream_io.vld_in && (win_end_s || frame_end_s);
      last_d   = stream_io.vld_in && frame_end_s;
`else
      emit_s   = stream_io.vld_in && win_end_s;
      last_d   = stream_io.vld_in && win_end_s && (seq_cnt_q == SEQ_LAST_FULL);
`endif
      vld_d    = emit_s;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         win_cnt_q <= '0;
         seq_cnt_q <= '0;
         vld_q     <= 1'b0;
         last_q    <= 1'b0;
      end else begin
         win_cnt_q <= win_cnt_d;
         seq_cnt_q <= seq_cnt_d;
         vld_q     <= vld_d;
         last_q    <= last_d;
      end
   end

   for (genvar g = 0; g < NO_CH; g++) begin : g_lane
      maxpool_time_stream_lane #(.BW(BW)) u_lane (
         .clk      (clk),
         .rst      (rst),
         .load_i   (load_s),
         .update_i (update_s),
         .emit_i   (emit_s),
         .data_i   (stream_io.data_in[g]),
         .data_o   (data_s[g])
      );
   end

   assign stream_io.vld_out  = vld_q;
   assign stream_io.last_out = last_q;
   assign stream_io.data_out = data_s;

endmodule

// File: tb/tb_maxpool_time_stream.sv
// Scoreboard bench: two pools (SEQ_LEN 4 and 5) share one stimulus stream and are
// compared against a window-list reference model.
module tb_maxpool_time_stream;

   localparam int NO_CH = 2;
   localparam int BW    = 3;
   localparam int POOL  = 2;
   localparam int SEQ_A = 4;
   localparam int SEQ_B = 5;
`ifdef MAXPOOL_FLUSH_PARTIAL_EN
   localparam bit FLUSH = 1'b1;
`else
   localparam bit FLUSH = 1'b0;
`endif

   typedef logic [NO_CH-1:0][BW-1:0] vec_t;
   typedef struct {
      vec_t data;
      logic last;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   maxpool_time_stream_if #(.NO_CH(NO_CH), .BW(BW)) bus_a ();
   maxpool_time_stream_if #(.NO_CH(NO_CH), .BW(BW)) bus_b ();

   assign bus_b.vld_in  = bus_a.vld_in;
   assign bus_b.data_in = bus_a.data_in;

   maxpool_time_stream #(.NO_CH(NO_CH), .BW(BW), .POOL_SIZE(POOL), .SEQ_LEN(SEQ_A)) dut_a (
      .clk(clk), .rst(rst), .stream_io(bus_a));
   maxpool_time_stream #(.NO_CH(NO_CH), .BW(BW), .POOL_SIZE(POOL), .SEQ_LEN(SEQ_B)) dut_b (
      .clk(clk), .rst(rst), .stream_io(bus_b));

   int   total = 0;
   int   bad   = 0;
   exp_t exp_a[$];
   exp_t exp_b[$];
   vec_t win_buf[2][POOL];
   int   win_len[2];
   int   pos[2];
   vec_t hold[2];
   logic rst_last = 1'b1;

   function automatic vec_t mk(input int c1, input int c0);
      vec_t v;
      v[1] = BW'(c1);
      v[0] = BW'(c0);
      return v;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         pos[d]     = 0;
         win_len[d] = 0;
      end
   endtask

   // Collect beats of a window; on completion the output is the per-channel max of the list.
   task automatic model_beat(input int d, input int seq_len, input vec_t x);
      int   rem;
      bit   emit;
      exp_t e;
      rem = seq_len % POOL;
      win_buf[d][win_len[d]] = x;
      win_len[d]++;
      pos[d]++;
      emit   = 1'b0;
      e.last = 1'b0;
      if (win_len[d] == POOL) begin
         emit   = 1'b1;
         e.last = (pos[d] == seq_len) || (!FLUSH && rem != 0 && pos[d] == seq_len - rem);
      end
      if (FLUSH && pos[d] == seq_len && win_len[d] > 0) begin
         emit   = 1'b1;
         e.last = 1'b1;
      end
      if (emit) begin
         for (int c = 0; c < NO_CH; c++) begin
            e.data[c] = '0;
            for (int i = 0; i < win_len[d]; i++) begin
               if (win_buf[d][i][c] > e.data[c]) e.data[c] = win_buf[d][i][c];
            end
         end
         if (d == 0) exp_a.push_back(e);
         else        exp_b.push_back(e);
         win_len[d] = 0;
      end
      if (pos[d] == seq_len) begin
         pos[d]     = 0;
         win_len[d] = 0;
      end
   endtask

   task automatic drive(input logic v, input vec_t x, input logic r);
      bus_a.vld_in  = v;
      bus_a.data_in = x;
      rst           = r;
      if (r) begin
         model_reset();
      end else if (v) begin
         model_beat(0, SEQ_A, x);
         model_beat(1, SEQ_B, x);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input int c1, input int c0);
      drive(1'b1, mk(c1, c0), 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, vec_t'($urandom), 1'b0);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b1);
   endtask

   task automatic check_out(input int d, input logic v, input vec_t dat, input logic l);
      exp_t e;
      total++;
      if (v) begin
         if ((d == 0 && exp_a.size() == 0) || (d == 1 && exp_b.size() == 0)) begin
            bad++;
            $display("FAIL unexpected_vld dut%0d got data=%h last=%b want no output", d, dat, l);
         end else begin
            if (d == 0) e = exp_a.pop_front();
            else        e = exp_b.pop_front();
            if (dat !== e.data || l !== e.last) begin
               bad++;
               $display("FAIL pool_out dut%0d got data=%h last=%b want data=%h last=%b",
                        d, dat, l, e.data, e.last);
            end
         end
         hold[d] = dat;
      end else if (dat !== hold[d] || l !== 1'b0) begin
         bad++;
         $display("FAIL idle_hold dut%0d got data=%h last=%b want data=%h last=0", d, dat, l, hold[d]);
      end
   endtask

   // Monitor: after a registered reset the outputs must be zero, otherwise follow the scoreboard.
   always @(negedge clk) begin
      if (rst_last) begin
         hold[0] = '0;
         hold[1] = '0;
      end
      check_out(0, bus_a.vld_out, bus_a.data_out, bus_a.last_out);
      check_out(1, bus_b.vld_out, bus_b.data_out, bus_b.last_out);
      rst_last = rst;
   end

   initial begin
      bus_a.vld_in  = 1'b0;
      bus_a.data_in = '0;
      model_reset();
      do_reset(3);

      // Basic pooling
      beat(6, 3); beat(2, 5); idle(2); do_reset(1);
      // Gap inside a window
      beat(1, 4); idle(3); beat(3, 2); idle(2); do_reset(1);
      // Frame tail: ch0 = 1,2,3,4,7
      beat(5, 1); beat(0, 2); beat(6, 3); beat(1, 4); beat(2, 7); idle(2); do_reset(1);
      // Reset mid-window, then realigned frame
      beat(0, 7); do_reset(1); beat(0, 1); beat(0, 2); beat(0, 3); beat(0, 4); beat(0, 5);
      idle(2); do_reset(1);
      // Full scale, unsigned, ties
      beat(0, 7); beat(7, 0); beat(7, 0); beat(0, 7); beat(4, 4); beat(4, 4); idle(2); do_reset(1);
      // Back-to-back frames
      for (int i = 0; i < 10; i++) beat(int'($urandom_range(7)), int'($urandom_range(7)));
      idle(2);

      // Random traffic with gaps, occasional resets, some coinciding with a beat
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom_range(9) < 7) ? 1'b1 : 1'b0, vec_t'($urandom),
               ($urandom_range(249) == 0) ? 1'b1 : 1'b0);
      end
      idle(4);

      total++;
      if (exp_a.size() != 0 || exp_b.size() != 0) begin
         bad++;
         $display("FAIL missing_out got pending a=%0d b=%0d want 0 0", exp_a.size(), exp_b.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/maxpool_time_stream.md
Name: maxpool_time_stream

Overview:
- Streaming 1-D temporal max-pool placed directly downstream of the BN/ReLU/quantize stage.
- Consumes NO_CH quantized, unsigned activations per valid beat and emits the per-channel maximum over each non-overlapping window of POOL_SIZE beats (stride = POOL_SIZE).
- Tracks position within a fixed-length frame of SEQ_LEN samples and marks the last pooled output of each frame, so the next conv layer can realign.

Parameters:
- NO_CH, 10, number of parallel channels.
- BW, 3, activation width in bits (unsigned, matches quantizer BW_OUT).
- POOL_SIZE, 2, window length and stride in valid beats; must be >= 1.
- SEQ_LEN, 1024, valid beats per frame; must be >= POOL_SIZE.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- vld_in, input, 1, data_in valid this cycle; no backpressure exists.
- data_in, input, [NO_CH-1:0][BW-1:0], quantized activations.
- vld_out, output, 1, data_out valid (single-cycle pulse per window).
- data_out, output, [NO_CH-1:0][BW-1:0], per-channel window maximum.
- last_out, output, 1, qualifies vld_out; high on the final pooled output of a frame.

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk. During and after reset, vld_out=0, last_out=0, data_out=0, win_cnt=0, seq_cnt=0, and all running-max registers are 0.
- Counters:
  - win_cnt runs 0..POOL_SIZE-1.
  - seq_cnt runs 0..SEQ_LEN-1, width $clog2(SEQ_LEN) (minimum 1).
  - Both advance only on vld_in.
- Running max, on vld_in:
  - If win_cnt==0: acc <= data_in.
  - Otherwise: acc <= max(acc, data_in).
  - Comparison is unsigned, per channel.
- Window completion, on vld_in with win_cnt==POOL_SIZE-1:
  - Next cycle: vld_out=1 and data_out = max(acc, data_in). With POOL_SIZE==1, data_out = data_in.
  - Latency is exactly 1 cycle after the completing beat.
  - win_cnt wraps to 0.
- vld_out stays high for one cycle only. data_out holds its last value while vld_out=0.
- Gaps: vld_in may drop for any number of cycles mid-window. acc and the counters hold, and the output depends only on valid beats.
- Frame end, on vld_in with seq_cnt==SEQ_LEN-1:
  - seq_cnt and win_cnt both reset to 0.
  - The next beat starts a new window in the new frame; windows never span frames.
- Tail: define REM = SEQ_LEN % POOL_SIZE and LAST_FULL = SEQ_LEN-REM-1.
  - When REM==0, the frame-end beat also completes a window and last_out=1 with that output.
  - When REM!=0, behaviour depends on the optional feature below.
- Reset mid-window or mid-frame discards the partial window. The first beat after reset is sample 0 of a new frame.
- Simultaneous rst and vld_in: rst wins and the beat is dropped.
- No arithmetic growth: output width equals BW.

Optional Feature:
- Macro: MAXPOOL_FLUSH_PARTIAL_EN.
- Defined:
  - When REM!=0, the frame-end beat (seq_cnt==SEQ_LEN-1) emits a pooled output over the REM trailing beats, one cycle later, with last_out=1.
  - The output for the window ending at LAST_FULL has last_out=0.
- Undefined:
  - Trailing REM beats are consumed and discarded; they produce no vld_out.
  - last_out=1 accompanies the output of the window ending at seq_cnt==LAST_FULL.

Decomposition:
- Shared package cnn_pkg:
  - localparams for the default NO_CH and BW, shared with bn_relu_quantize.
  - typedef act_t = logic [BW-1:0].
  - Function umax(a,b).
- Sub-module maxpool_lane: one channel's acc register, plus the compare/load mux and output register, driven by shared load/update/emit strobes from the top.
- The top holds win_cnt, seq_cnt, tail logic and vld_out/last_out, and generates NO_CH instances of maxpool_lane.

Test Plan:
1. Basic pooling: NO_CH=2, BW=3, POOL_SIZE=2, SEQ_LEN=4. Drive ch0 = 3 then 5, ch1 = 6 then 2, on consecutive cycles -> vld_out one cycle after the 2nd beat, data_out = {ch1=6, ch0=5}, last_out=0.
2. Gaps: same config. Send beat 1, hold vld_in=0 for 3 cycles, then send beat 2 -> exactly one vld_out, 1 cycle after beat 2, with the correct max; no spurious pulses.
3. Tail handling: POOL_SIZE=2, SEQ_LEN=5, ch0 = 1,2,3,4,7.
   - With macro: outputs 2, 4, 7; last_out only on 7.
   - Without macro: outputs 2, 4; last_out on 4; the 7 is never output.
4. Reset mid-window: one beat of ch0=7, then rst for 1 cycle, then beats 1,2 -> output 2 (not 7); the seq_cnt restart is verified via last_out position.
5. Full-scale, unsigned, and ties: inputs 7,0 -> 7; 0,7 -> 7; 4,4 -> 4; BW=3, so 7 must not be treated as negative.
6. Back-to-back frames: SEQ_LEN=4, 8 continuous beats -> 4 outputs, last_out on the 2nd and 4th; frame 2 results are independent of frame 1 values.
